// File: rtl/pagerank_pkg.sv
// rtl/pagerank_pkg.sv - shared FSM type, width and saturation helpers for pagerank_engine
package pagerank_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    COMMIT = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Q0.16 defaults: ~0.85 damping and ~0.15/16 base
  localparam logic [15:0] DAMP_DEFAULT = 16'hD99A;
  localparam logic [15:0] BASE_DEFAULT = 16'h0266;

  function automatic int acc_width(input int n, input int width);
    return width + $clog2(n);
  endfunction

  function automatic logic [63:0] saturate(input logic [63:0] v, input int width);
    logic [63:0] vmax;
    vmax = (64'd1 << width) - 64'd1;
    return (v > vmax) ? vmax : v;
  endfunction

endpackage

// File: rtl/pagerank_contrib.sv
// rtl/pagerank_contrib.sv - WIDTHxWIDTH fixed-point multiply keeping the high half (truncated)
module pagerank_contrib #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] p
);

  logic [2*WIDTH-1:0] prod;

  assign prod = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
  assign p    = prod[2*WIDTH-1:WIDTH];

endmodule

// File: rtl/pagerank_engine.sv
// rtl/pagerank_engine.sv - iterative PageRank core, one source per cycle plus a commit cycle per iteration
// Optional damping at commit is enabled by defining PAGERANK_DAMPING_EN.
module pagerank_engine
  import pagerank_pkg::*;
#(
  parameter int N = 16,
  parameter int WIDTH = 16,
  parameter logic [WIDTH-1:0] INIT_RANK = WIDTH'((64'd1 << WIDTH) / 64'(N)),
  parameter int ITER_W = 8
`ifdef PAGERANK_DAMPING_EN
  ,
  parameter logic [WIDTH-1:0] DAMP = WIDTH'(DAMP_DEFAULT),
  parameter logic [WIDTH-1:0] BASE = WIDTH'(BASE_DEFAULT)
`endif
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [ITER_W-1:0]    iter_cnt,
  input  logic [N*N-1:0]       adj,
  input  logic [N*WIDTH-1:0]   node_weight,
  output logic                 busy,
  output logic                 done,
  output logic [ITER_W-1:0]    iter_idx,
  output logic [N*WIDTH-1:0]   rank_out,
  output logic [WIDTH-1:0]     node0_val
);

  localparam int ACC_W = acc_width(N, WIDTH);
  localparam int SRC_W = $clog2(N);
  localparam logic [SRC_W-1:0] SRC_LAST = SRC_W'(N - 1);

  state_t state, state_nxt;

  logic [N*N-1:0]     adj_q;
  logic [N*WIDTH-1:0] weight_q;
  logic [ITER_W-1:0]  iter_tgt;
  logic [SRC_W-1:0]   src;
  logic [WIDTH-1:0]   rank [N];
  logic [ACC_W-1:0]   acc [N];
  logic [WIDTH-1:0]   rank_commit [N];
  logic [WIDTH-1:0]   rank_sel;
  logic [WIDTH-1:0]   weight_sel;
  logic [WIDTH-1:0]   contrib;

  assign rank_sel   = rank[src];
  assign weight_sel = weight_q[src*WIDTH +: WIDTH];

  pagerank_contrib #(.WIDTH(WIDTH)) u_contrib (
    .a (rank_sel),
    .b (weight_sel),
    .p (contrib)
  );

  // Commit needs every node's new rank in the same cycle to keep N+1 cycles per iteration
  for (genvar d = 0; d < N; d++) begin : g_node
    logic [WIDTH-1:0] acc_clamped;
    assign acc_clamped = WIDTH'(saturate(64'(acc[d]), WIDTH));
`ifdef PAGERANK_DAMPING_EN
    logic [WIDTH-1:0] damped;
    pagerank_contrib #(.WIDTH(WIDTH)) u_damp (
      .a (acc_clamped),
      .b (DAMP),
      .p (damped)
    );
    assign rank_commit[d] = WIDTH'(saturate(64'(BASE) + 64'(damped), WIDTH));
`else
    assign rank_commit[d] = acc_clamped;
`endif
    assign rank_out[d*WIDTH +: WIDTH] = rank[d];
  end

  assign node0_val = rank_out[WIDTH-1:0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (iter_cnt != '0) ? ACCUM : DONE;
      ACCUM:   if (src == SRC_LAST) state_nxt = COMMIT;
      COMMIT:  state_nxt = ((iter_idx + ITER_W'(1)) == iter_tgt) ? DONE : ACCUM;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
    done = (state == DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      adj_q    <= '0;
      weight_q <= '0;
      iter_tgt <= '0;
      src      <= '0;
      iter_idx <= '0;
      for (int k = 0; k < N; k++) begin
        rank[k] <= '0;
        acc[k]  <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            adj_q    <= adj;
            weight_q <= node_weight;
            iter_tgt <= iter_cnt;
            src      <= '0;
            iter_idx <= '0;
            for (int k = 0; k < N; k++) begin
              rank[k] <= INIT_RANK;
              acc[k]  <= '0;
            end
          end
        end
        ACCUM: begin
          for (int d = 0; d < N; d++) begin
            if (adj_q[int'(src)*N + d]) acc[d] <= acc[d] + ACC_W'(contrib);
          end
          src <= (src == SRC_LAST) ? '0 : src + SRC_W'(1);
        end
        COMMIT: begin
          for (int d = 0; d < N; d++) begin
            rank[d] <= rank_commit[d];
            acc[d]  <= '0;
          end
          iter_idx <= iter_idx + ITER_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pagerank_engine.sv
// tb/tb_pagerank_engine.sv - self-checking bench for pagerank_engine (N=4 and default N=16 instances)
module tb_pagerank_engine;

  localparam longint DAMPV  = 64'hD99A;
  localparam longint BASE4  = 64'h099A;
  localparam longint BASE16 = 64'h0266;

  logic clk = 1'b0;
  logic reset = 1'b0;

  logic        start4 = 1'b0;
  logic [7:0]  iter4 = '0;
  logic [15:0] adj4 = '0;
  logic [63:0] w4 = '0;
  logic        busy4, done4;
  logic [7:0]  idx4;
  logic [63:0] rank4;
  logic [15:0] n0_4;

  logic         start16 = 1'b0;
  logic [7:0]   iter16 = '0;
  logic [255:0] adj16 = '0;
  logic [255:0] w16 = '0;
  logic         busy16, done16;
  logic [7:0]   idx16;
  logic [255:0] rank16;
  logic [15:0]  n0_16;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

`ifdef PAGERANK_DAMPING_EN
  pagerank_engine #(.N(4), .WIDTH(16), .INIT_RANK(16'h4000), .ITER_W(8), .BASE(16'h099A)) u_dut4 (
`else
  pagerank_engine #(.N(4), .WIDTH(16), .INIT_RANK(16'h4000), .ITER_W(8)) u_dut4 (
`endif
    .clk(clk), .reset(reset), .start(start4), .iter_cnt(iter4), .adj(adj4),
    .node_weight(w4), .busy(busy4), .done(done4), .iter_idx(idx4),
    .rank_out(rank4), .node0_val(n0_4)
  );

  pagerank_engine u_dut16 (
    .clk(clk), .reset(reset), .start(start16), .iter_cnt(iter16), .adj(adj16),
    .node_weight(w16), .busy(busy16), .done(done16), .iter_idx(idx16),
    .rank_out(rank16), .node0_val(n0_16)
  );

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference: new rank of d = clamp of the sum over in-linking sources s of floor(rank[s]*w[s]/2^16)
  function automatic logic [255:0] model(input int n, input longint init, input longint base,
                                         input logic [255:0] a, input logic [255:0] w, input int k);
    longint r [16];
    longint acc [16];
    longint c, v;
    logic [255:0] res;
    for (int i = 0; i < 16; i++) r[i] = (i < n) ? init : 0;
    for (int it = 0; it < k; it++) begin
      for (int d = 0; d < 16; d++) acc[d] = 0;
      for (int s = 0; s < n; s++) begin
        c = (r[s] * longint'(w[s*16 +: 16])) / 65536;
        for (int d = 0; d < n; d++) if (a[s*n + d]) acc[d] += c;
      end
      for (int d = 0; d < n; d++) begin
        v = (acc[d] > 65535) ? 65535 : acc[d];
`ifdef PAGERANK_DAMPING_EN
        v = base + (v * DAMPV) / 65536;
        if (v > 65535) v = 65535;
`endif
        r[d] = v;
      end
    end
    res = '0;
    for (int d = 0; d < n; d++) res[d*16 +: 16] = 16'(r[d]);
    if (base < 0) res = '1;
    return res;
  endfunction

  task automatic run4(input logic [15:0] a, input logic [63:0] w, input int k,
                      output int cyc, output logic [63:0] r, output logic [7:0] idx);
    int guard;
    guard = 0;
    @(negedge clk);
    while (busy4 && guard < 400) begin @(negedge clk); guard++; end
    adj4 = a; w4 = w; iter4 = 8'(k); start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0; adj4 = 16'($urandom); w4 = {$urandom, $urandom}; iter4 = 8'($urandom);
    cyc = 1;
    while (!done4 && cyc < 400) begin @(posedge clk); #1; cyc++; end
    r = rank4; idx = idx4;
  endtask

  task automatic run16(input logic [255:0] a, input logic [255:0] w, input int k,
                       output int cyc, output logic [255:0] r, output logic [7:0] idx);
    int guard;
    guard = 0;
    @(negedge clk);
    while (busy16 && guard < 400) begin @(negedge clk); guard++; end
    adj16 = a; w16 = w; iter16 = 8'(k); start16 = 1'b1;
    @(posedge clk); #1;
    start16 = 1'b0; adj16 = '0; w16 = '1; iter16 = 8'($urandom);
    cyc = 1;
    while (!done16 && cyc < 400) begin @(posedge clk); #1; cyc++; end
    r = rank16; idx = idx16;
  endtask

  typedef struct {
    string       name;
    logic [15:0] adj;
    logic [63:0] w;
    int          k;
    logic [63:0] exp_rank;
  } vec_t;

  initial begin
    vec_t vecs [4];
    int cyc, pulses;
    logic [63:0] r4;
    logic [255:0] r16, e16, a16, wv16;
    logic [7:0] idx;
    logic [15:0] ra;
    logic [63:0] rw;
    int rk;
    int edges [14][2];
    logic [15:0] wpat [4];

    vecs[0] = '{"ring",  16'h1842, 64'hFFFF_FFFF_FFFF_FFFF, 1, 64'h3FFF_3FFF_3FFF_3FFF};
    vecs[1] = '{"star",  16'h1110, 64'hFFFF_FFFF_FFFF_FFFF, 1, 64'h0000_0000_0000_BFFD};
    vecs[2] = '{"sat",   16'hFFFF, 64'hFFFF_FFFF_FFFF_FFFF, 2, 64'hFFFF_FFFF_FFFF_FFFF};
    vecs[3] = '{"k0",    16'h1842, 64'hFFFF_FFFF_FFFF_FFFF, 0, 64'h4000_4000_4000_4000};
`ifdef PAGERANK_DAMPING_EN
    for (int i = 0; i < 3; i++)
      vecs[i].exp_rank = 64'(model(4, 64'h4000, BASE4, 256'(vecs[i].adj), 256'(vecs[i].w), vecs[i].k));
`endif

    // reset state
    #12;
    check("rst_busy4", 256'(busy4), 256'(0));
    check("rst_done4", 256'(done4), 256'(0));
    check("rst_idx4", 256'(idx4), 256'(0));
    check("rst_rank4", 256'(rank4), 256'(0));
    check("rst_rank16", rank16, 256'(0));
    @(negedge clk); reset = 1'b1;

    // table vectors, each started in the IDLE cycle right after the previous DONE
    for (int i = 0; i < 4; i++) begin
      run4(vecs[i].adj, vecs[i].w, vecs[i].k, cyc, r4, idx);
      check({vecs[i].name, "_lat"}, 256'(cyc), 256'(vecs[i].k * 5 + 1));
      check({vecs[i].name, "_rank"}, 256'(r4), 256'(vecs[i].exp_rank));
      check({vecs[i].name, "_idx"}, 256'(idx), 256'(vecs[i].k));
      check({vecs[i].name, "_node0"}, 256'(n0_4), 256'(vecs[i].exp_rank[15:0]));
    end

    // start pulsed mid-run with different inputs must be ignored
    @(negedge clk);
    while (busy4) @(negedge clk);
    adj4 = 16'h1842; w4 = '1; iter4 = 8'd1; start4 = 1'b1;
    @(posedge clk); #1; start4 = 1'b0; cyc = 1;
    @(posedge clk); #1; cyc++;
    @(posedge clk); #1; cyc++;
    adj4 = 16'h1110; w4 = 64'h1234_5678_9ABC_DEF0; iter4 = 8'd3; start4 = 1'b1;
    @(posedge clk); #1; cyc++; start4 = 1'b0;
    while (!done4 && cyc < 400) begin @(posedge clk); #1; cyc++; end
    check("midstart_lat", 256'(cyc), 256'(6));
    check("midstart_rank", 256'(rank4), model(4, 64'h4000, BASE4, 256'(16'h1842), 256'(64'hFFFF_FFFF_FFFF_FFFF), 1));
    repeat (10) @(posedge clk);
    #1 check("midstart_idle", 256'(busy4), 256'(0));

    // randomized N=4 runs against the model
    for (int i = 0; i < 8; i++) begin
      ra = 16'($urandom); rw = {$urandom, $urandom}; rk = int'($urandom_range(0, 4));
      run4(ra, rw, rk, cyc, r4, idx);
      check($sformatf("rand4_%0d_lat", i), 256'(cyc), 256'(rk * 5 + 1));
      check($sformatf("rand4_%0d_rank", i), 256'(r4), model(4, 64'h4000, BASE4, 256'(ra), 256'(rw), rk));
    end

    // default N=16 graph, 14 edges, weights cycling 0x5555/0x8000/0xFFFF/0x8000
    edges = '{'{0,1},'{1,2},'{2,0},'{3,0},'{4,0},'{5,6},'{6,7},'{7,0},'{8,9},'{9,0},'{10,11},'{11,12},'{12,0},'{13,14}};
    wpat = '{16'h5555, 16'h8000, 16'hFFFF, 16'h8000};
    a16 = '0; wv16 = '0;
    for (int e = 0; e < 14; e++) a16[edges[e][0]*16 + edges[e][1]] = 1'b1;
    for (int k = 0; k < 16; k++) wv16[k*16 +: 16] = wpat[k % 4];
    e16 = model(16, 64'h1000, BASE16, a16, wv16, 3);
    run16(a16, wv16, 3, cyc, r16, idx);
    check("g16_lat", 256'(cyc), 256'(52));
    check("g16_node0", 256'(n0_16), 256'(e16[15:0]));
    check("g16_rank", r16, e16);
    check("g16_idx", 256'(idx), 256'(3));

    for (int i = 0; i < 3; i++) begin
      a16 = {8{$urandom}};
      for (int k = 0; k < 8; k++) wv16[k*32 +: 32] = $urandom;
      rk = int'($urandom_range(1, 3));
      e16 = model(16, 64'h1000, BASE16, a16, wv16, rk);
      run16(a16, wv16, rk, cyc, r16, idx);
      check($sformatf("rand16_%0d_lat", i), 256'(cyc), 256'(rk * 17 + 1));
      check($sformatf("rand16_%0d_rank", i), r16, e16);
    end

    // reset asserted mid-ACCUM aborts with no done
    @(negedge clk);
    while (busy4) @(negedge clk);
    adj4 = 16'hFFFF; w4 = '1; iter4 = 8'd2; start4 = 1'b1;
    @(posedge clk); #1; start4 = 1'b0;
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("abort_busy", 256'(busy4), 256'(0));
    check("abort_rank", 256'(rank4), 256'(0));
    check("abort_idx", 256'(idx4), 256'(0));
    @(negedge clk); reset = 1'b1;
    pulses = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (done4 || busy4) pulses++;
    end
    check("abort_no_done", 256'(pulses), 256'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
